// File: rtl/lfsr_decrypt_ctrl_if.sv
// Data-memory port bundle for the LFSR decrypt sequencer.
// Reads are combinational; writes commit on the next clock edge.
interface lfsr_decrypt_ctrl_if;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/lfsr_decrypt_ctrl.sv
// LFSR decrypt sequencer: recovers seed and tap from the space
// preamble, then writes space-stripped plaintext to memory.
module lfsr_decrypt_ctrl #(
  parameter int SRC_BASE  = 64,
  parameter int MSG_LEN   = 64,
  parameter int DST_LEN   = 55,
  parameter int PROBE_LEN = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  lfsr_decrypt_ctrl_if.master        mem,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 tap_sel
);

  typedef enum logic [2:0] {
    IDLE, SEED, PROBE, NEXT_TAP,
    DECRYPT, PAD, DONE, FAIL
  } state_t;

  localparam logic [7:0] SP   = 8'h20;
  localparam logic [7:0] BASE = 8'(SRC_BASE);
  localparam logic [5:0] DST  = 6'(DST_LEN);
  localparam logic [5:0] JMAX = 6'(MSG_LEN - 1);
  localparam logic [3:0] PMAX = 4'(PROBE_LEN);

  state_t     state, state_n;
  logic [7:0] seed, seed_n;
  logic [7:0] lfsr, lfsr_n;
  logic [2:0] k, k_n;
  logic [2:0] tap_n;
  logic [3:0] i, i_n;
  logic [5:0] j, j_n;
  logic [5:0] out_cnt, out_n;
  logic       seen, seen_n;
  logic [7:0] lfsr_adv;
  logic [7:0] p;
  logic       wr_ok;

  function automatic logic [7:0] tap_rom(
    input logic [2:0] idx
  );
    logic [7:0] t;
    t = 8'he1;
    unique case (idx)
      3'd0: t = 8'he1;
      3'd1: t = 8'hd4;
      3'd2: t = 8'hc6;
      3'd3: t = 8'hb8;
      3'd4: t = 8'hb4;
      3'd5: t = 8'hb2;
      3'd6: t = 8'hfa;
      3'd7: t = 8'hf3;
    endcase
    return t;
  endfunction

  assign lfsr_adv = {lfsr[6:0], ^(lfsr & tap_rom(k))};
  assign p        = mem.rd_data ^ lfsr;
  assign wr_ok    = ((p != SP) || seen) && (out_cnt < DST);

  assign busy  = !(state inside {IDLE, DONE, FAIL});
  assign done  = (state == DONE) || (state == FAIL);
  assign error = (state == FAIL);

  always_comb begin
    state_n     = state;
    seed_n      = seed;
    lfsr_n      = lfsr;
    k_n         = k;
    tap_n       = tap_sel;
    i_n         = i;
    j_n         = j;
    out_n       = out_cnt;
    seen_n      = seen;
    mem.rd_addr = 8'h00;
    mem.wr_en   = 1'b0;
    mem.wr_addr = 8'h00;
    mem.wr_data = 8'h00;
    unique case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n = SEED;
          k_n     = 3'd0;
          i_n     = 4'd0;
          j_n     = 6'd0;
          out_n   = 6'd0;
          seen_n  = 1'b0;
        end
      end
      SEED: begin
        mem.rd_addr = BASE;
        seed_n      = mem.rd_data ^ SP;
        lfsr_n      = mem.rd_data ^ SP;
        k_n         = 3'd0;
        i_n         = 4'd1;
        state_n     = PROBE;
      end
      PROBE: begin
        mem.rd_addr = BASE + {4'd0, i};
        lfsr_n      = lfsr_adv;
        if ((mem.rd_data ^ lfsr_adv) != SP) begin
          state_n = NEXT_TAP;
        end else if (i == PMAX) begin
          // decrypt restarts from the seed at byte 0
          tap_n   = k;
          lfsr_n  = seed;
          j_n     = 6'd0;
          out_n   = 6'd0;
          seen_n  = 1'b0;
          state_n = DECRYPT;
        end else begin
          i_n = i + 4'd1;
        end
      end
      NEXT_TAP: begin
        if (k == 3'd7) begin
          state_n = FAIL;
        end else begin
          k_n     = k + 3'd1;
          lfsr_n  = seed;
          i_n     = 4'd1;
          state_n = PROBE;
        end
      end
      DECRYPT: begin
        mem.rd_addr = BASE + {2'd0, j};
        lfsr_n      = lfsr_adv;
        if (p != SP) seen_n = 1'b1;
        if (wr_ok) begin
          mem.wr_en   = 1'b1;
          mem.wr_addr = {2'd0, out_cnt};
          mem.wr_data = p;
          out_n       = out_cnt + 6'd1;
        end
        if (j == JMAX) begin
          state_n = (out_n == DST) ? DONE : PAD;
        end else begin
          j_n = j + 6'd1;
        end
      end
      PAD: begin
        mem.wr_en   = 1'b1;
        mem.wr_addr = {2'd0, out_cnt};
        mem.wr_data = SP;
        out_n       = out_cnt + 6'd1;
        if (out_n == DST) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      seed    <= 8'h00;
      lfsr    <= 8'h00;
      k       <= 3'd0;
      tap_sel <= 3'd0;
      i       <= 4'd0;
      j       <= 6'd0;
      out_cnt <= 6'd0;
      seen    <= 1'b0;
    end else begin
      state   <= state_n;
      seed    <= seed_n;
      lfsr    <= lfsr_n;
      k       <= k_n;
      tap_sel <= tap_n;
      i       <= i_n;
      j       <= j_n;
      out_cnt <= out_n;
      seen    <= seen_n;
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Bench for lfsr_decrypt_ctrl: vector table, write scoreboard,
// plus reset-mid-run, start-while-busy and rerun sequences.
module tb_lfsr_decrypt_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, error;
  logic [2:0] tap_sel;
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;
  logic [7:0] ram [0:255];

  lfsr_decrypt_ctrl_if m ();

  lfsr_decrypt_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mem     (m),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .tap_sel (tap_sel)
  );

  always #5 clk = ~clk;

  assign m.rd_data = ram[m.rd_addr];

  always @(posedge clk) begin
    if (m.wr_en) ram[m.wr_addr] <= m.wr_data;
    if (ld_en) ram[ld_addr] <= ld_data;
  end

  typedef struct {
    int         tap;
    logic [7:0] seed;
    int         pre;
    int         mode;
    int         corrupt;
    bit         poke;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q [$];
  logic [7:0] taps [8];
  logic [7:0] ctb [64];
  logic [7:0] exp_mem [55];
  int         exp_tap, exp_err, exp_lat, exp_probe;
  int         total = 0;
  int         bad = 0;
  vec_t       vecs [6];

  function automatic logic [7:0] step(
    input logic [7:0] s, input logic [7:0] t
  );
    return {s[6:0], ^(s & t)};
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic prep(input vec_t v);
    logic [7:0] pt [64];
    logic [7:0] l, p;
    int n, w;
    bit ok, sn;
    for (int x = 0; x < 64; x++) begin
      if (x < v.pre) pt[x] = 8'h20;
      else case (v.mode)
        0: pt[x] = (x == v.pre)     ? 8'h48 :
                   (x == v.pre + 1) ? 8'h69 :
                   (x == v.pre + 2) ? 8'h2e : 8'h20;
        2: pt[x] = 8'h41 + 8'(x % 26);
        3: pt[x] = (x % 5 == 0) ? 8'h20 : 8'h61 + 8'(x % 26);
        default: pt[x] = 8'h20;
      endcase
    end
    l = v.seed;
    for (int x = 0; x < 64; x++) begin
      ctb[x] = pt[x] ^ l;
      l = step(l, taps[v.tap]);
    end
    if (v.corrupt > 0) ctb[v.corrupt] = ctb[v.corrupt] ^ 8'h01;
    exp_q.delete();
    exp_err = 1;
    exp_tap = 0;
    exp_probe = 0;
    for (int k = 0; k < 8; k++) begin
      l = ctb[0] ^ 8'h20;
      ok = 1;
      n = 0;
      for (int x = 1; x <= 8; x++) begin
        l = step(l, taps[k]);
        n = x;
        if ((ctb[x] ^ l) != 8'h20) begin
          ok = 0;
          break;
        end
      end
      if (ok) begin
        exp_err = 0;
        exp_tap = k;
        exp_probe += 8;
        break;
      end
      exp_probe += n + 1;
    end
    exp_lat = 1 + exp_probe;
    for (int a = 0; a < 55; a++) exp_mem[a] = 8'haa;
    if (exp_err == 0) begin
      l = ctb[0] ^ 8'h20;
      sn = 0;
      w = 0;
      for (int x = 0; x < 64; x++) begin
        p = ctb[x] ^ l;
        l = step(l, taps[exp_tap]);
        if (p != 8'h20) sn = 1;
        if (sn && w < 55) begin
          exp_q.push_back('{a: 8'(w), d: p});
          exp_mem[w] = p;
          w++;
        end
      end
      exp_lat += 64 + 55 - w;
      while (w < 55) begin
        exp_q.push_back('{a: 8'(w), d: 8'h20});
        exp_mem[w] = 8'h20;
        w++;
      end
    end
  endtask

  task automatic load();
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = (a < 64) ? 8'haa : ctb[a - 64];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input bit poke, input int rst_at);
    int cyc;
    int nbad;
    wr_t w;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (m.wr_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_wr: got %0h:%0h want none",
                   m.wr_addr, m.wr_data);
        end else begin
          w = exp_q.pop_front();
          chk("wr", {m.wr_addr, m.wr_data}, {w.a, w.d});
        end
      end
      start = poke && (cyc == 30);
      if (cyc == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", m.wr_en, 0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("latency", cyc, exp_lat);
    chk("error", error, exp_err);
    if (exp_err == 0) chk("tap_sel", tap_sel, exp_tap);
    chk("sb_left", exp_q.size(), 0);
    nbad = 0;
    for (int a = 0; a < 55; a++)
      if (ram[a] !== exp_mem[a]) nbad++;
    chk("mem", nbad, 0);
  endtask

  initial begin
    taps = '{8'he1, 8'hd4, 8'hc6, 8'hb8,
             8'hb4, 8'hb2, 8'hfa, 8'hf3};
    vecs[0] = '{7, 8'h01, 12, 0, 0, 0};
    vecs[1] = '{0, 8'h5a, 64, 1, 0, 0};
    vecs[2] = '{4, 8'h37, 12, 0, 6, 0};
    vecs[3] = '{2, 8'h9c,  9, 2, 0, 0};
    vecs[4] = '{3, 8'h00, 10, 3, 0, 0};
    vecs[5] = '{6, 8'hc3, 15, 3, 0, 1};
    reset   = 1'b1;
    start   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_state",
        {busy, done, error, tap_sel, m.wr_en,
         m.rd_addr, m.wr_addr, m.wr_data}, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      prep(vecs[v]);
      load();
      run(vecs[v].poke, -1);
    end

    prep(vecs[5]);
    run(1'b0, -1);

    prep(vecs[3]);
    load();
    run(1'b0, 1 + exp_probe + 20);
    prep(vecs[3]);
    load();
    run(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_decrypt_ctrl.md
Name: lfsr_decrypt_ctrl

Overview:
- Hardware sequencer for the LFSR decryption task (program 2) that runs against the shared data memory.
- On start it reads the 64-byte ciphertext at addresses 64..127 and recovers the LFSR seed from the known space preamble.
- It identifies which of the 8 maximal-length tap patterns was used, then decrypts the message.
- It writes the plaintext, with leading spaces stripped, to addresses 0..54 and raises done.

Parameters:
- SRC_BASE, 64, first ciphertext address.
- MSG_LEN, 64, ciphertext bytes processed.
- DST_LEN, 55, plaintext bytes written starting at address 0.
- PROBE_LEN, 8, preamble bytes after byte 0 checked per tap candidate (preamble is always >8).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns to IDLE.
- start  in  1  single-cycle pulse; sampled in IDLE, DONE and FAIL only.
- rd_addr  out  8  data-memory read address; read is combinational.
- rd_data  in  8  memory contents at rd_addr, valid in the same cycle.
- wr_en  out  1  data-memory write strobe; the write commits on the next rising edge.
- wr_addr  out  8  write address.
- wr_data  out  8  write data.
- busy  out  1  high in any state other than IDLE, DONE or FAIL.
- done  out  1  high in DONE and in FAIL.
- error  out  1  high in FAIL only.
- tap_sel  out  3  index of the detected tap pattern, valid when done=1 and error=0.

Behaviour:
- Tap ROM, indexed 0..7: e1, d4, c6, b8, b4, b2, fa, f3.
- LFSR step: next = {s[6:0], ^(s & tap)}. Plaintext byte i = ct[SRC_BASE+i] ^ lfsr_i, where lfsr_0 is the seed.
- Reset values: busy=0, done=0, error=0, tap_sel=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. Internal state is IDLE with all counters at 0.
- States:
  - IDLE: on start go to SEED; otherwise stay.
  - SEED (1 cycle): rd_addr=64; seed <= rd_data ^ 8'h20; k <= 0; go to PROBE, loading lfsr <= seed with tap[0] and i <= 1.
  - PROBE: each cycle rd_addr=64+i and lfsr advances one step.
    - Compare rd_data ^ next(lfsr) against 8'h20.
    - On mismatch go to NEXT_TAP.
    - On a match with i==PROBE_LEN, latch tap_sel<=k and go to DECRYPT.
    - On a match otherwise, i++.
  - NEXT_TAP (1 cycle): if k==7 go to FAIL. Otherwise k++, lfsr<=seed, i<=1, return to PROBE.
  - DECRYPT: j runs 0..63, one byte per cycle; rd_addr=64+j, p = rd_data ^ lfsr, then lfsr advances.
    - A sticky flag `seen` is set on the first p != 8'h20.
    - When p != 8'h20 or seen is already set, and out_cnt<DST_LEN: wr_en=1, wr_addr=out_cnt, wr_data=p, out_cnt++.
    - Leading spaces are dropped. Bytes beyond DST_LEN are dropped silently.
    - After j==63 go to PAD.
  - PAD: while out_cnt<DST_LEN, write 8'h20 to wr_addr=out_cnt and out_cnt++. Then go to DONE.
  - DONE and FAIL: hold done=1 until reset or start. Start clears done, error and the counters and enters SEED on the next edge.
- The first matching tap in index order wins. A zero seed (ct[64]==8'h20) matches tap 0 immediately and decrypts with lfsr constant 0.
- FAIL: performs no memory writes. tap_sel holds its previous value.
- start while busy=1 is ignored.
- reset mid-operation: wr_en=0 from the following cycle onward. Partial writes already committed are not undone.
- Latency, no wrap or overflow: 1 (SEED) + probe cycles (≤8 per tap plus 1 per rejected tap) + 64 (DECRYPT) + (55 − bytes written) (PAD) cycles, then DONE.
- All address arithmetic is 8-bit. Addresses never exceed 127.

Test Plan:
- Tap f3, seed 01, preamble 12, plaintext "Hi." with trailing spaces; ct[64..66] = 21, 23, 26 -> tap_sel=7, error=0, mem[0..2] = 48 69 2E, mem[3..54] = 20.
- Tap e1, seed 5A, all-space plaintext -> tap_sel=0, mem[0..54] all 20, done high within 1+8+64+55 cycles.
- Ciphertext byte 70 corrupted for every candidate (ct[70] ^= 01 after encryption with tap b4) -> error=1, done=1, no wr_en pulse observed.
- 64-byte plaintext with no spaces, preamble forced to 9 spaces -> exactly 55 writes, with 0 PAD cycles.
- reset asserted during DECRYPT at j=20 -> next cycle busy=0, wr_en=0; a new start gives a correct full decrypt.
- start pulsed while busy -> no restart and the cycle count is unchanged; a start in DONE reruns and produces identical memory contents.
